// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter
// -----------------
// Per-slave arbiter that sits behind the per-master address decoders. Each master's
// decoder raises its hreq bit for this slave. One master at a time gets a round-robin
// grant, and keeps it for the whole of a fixed-length burst. An undefined-length INCR
// burst keeps the grant only until MAX_INCR_BEATS beats have gone by while another
// master is waiting. The grant moves only on cycles where hready=1.
//
// Ports
//   hclk              clock, all state updates on the rising edge
//   hreset            synchronous active-high reset
//   hreq              request per master (from that master's decoder)
//   htrans_m          htrans per master, master i at [2i+1:2i]
//   hburst_m          hburst per master, master i at [3i+2:3i]
//   hready            slave hreadyout (1 = current data phase completes)
//   hgrant            registered one-hot grant, all-zero when idle
//   hmaster_sel       index of the granted master (address-phase mux select)
//   hmaster_data_sel  index of the master owning the current data phase
//   hsel_data_valid   current data phase belongs to a real (NONSEQ/SEQ) transfer

module ahb_slave_arbiter #(
    parameter int   SLAVE_X_MASTER_NUM = 3,
    parameter int   MAX_INCR_BEATS     = 16,
    localparam int  MSEL_W             = $clog2(SLAVE_X_MASTER_NUM)
) (
    input  logic                            hclk,
    input  logic                            hreset,
    input  logic [SLAVE_X_MASTER_NUM-1:0]   hreq,
    input  logic [2*SLAVE_X_MASTER_NUM-1:0] htrans_m,
    input  logic [3*SLAVE_X_MASTER_NUM-1:0] hburst_m,
    input  logic                            hready,
    output logic [SLAVE_X_MASTER_NUM-1:0]   hgrant,
    output logic [MSEL_W-1:0]               hmaster_sel,
    output logic [MSEL_W-1:0]               hmaster_data_sel,
    output logic                            hsel_data_valid
);

    localparam int N     = SLAVE_X_MASTER_NUM;
    localparam int CNT_W = $clog2(MAX_INCR_BEATS + 1);
    localparam logic [CNT_W-1:0] INCR_LIMIT = CNT_W'(MAX_INCR_BEATS);

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_OWN  = 1'b1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    // Registered state
    logic [0:0]        state_q,    state_d;
    logic [N-1:0]      grant_q,    grant_d;
    logic [MSEL_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;   // beats still to come in a fixed burst
    logic [CNT_W-1:0]  incr_cnt_q, incr_cnt_d;   // beats seen in an INCR burst, saturating
    logic              in_incr_q,  in_incr_d;    // current burst is undefined-length INCR
    logic [MSEL_W-1:0] data_sel_q;
    logic              data_valid_q;

    // Owner view
    logic [1:0]        own_trans;
    logic [2:0]        own_burst;
    logic [MSEL_W-1:0] own_sel;
    logic              own_req;

    // Next-state helpers
    logic [N-1:0]      others;
    logic [N-1:0]      grant_req;
    logic [MSEL_W-1:0] winner;
    logic [CNT_W-1:0]  incr_next;
    logic              do_grant;
    logic              last_fixed;
    logic              incr_limit;
    logic              release_own;

    // First requester at or after ptr, wrapping modulo N.
    function automatic logic [MSEL_W-1:0] rr_pick(input logic [N-1:0]      req,
                                                  input logic [MSEL_W-1:0] ptr);
        logic [MSEL_W-1:0] pick;
        logic [MSEL_W-1:0] cand_w;
        logic              found;
        int                cand;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_w = MSEL_W'(cand);
            if (!found && req[cand_w]) begin
                pick  = cand_w;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Beats remaining after the NONSEQ beat of a burst. INCR and SINGLE both give 0.
    // INCR is tracked separately by incr_cnt.
    function automatic logic [3:0] burst_last_idx(input logic [2:0] burst);
        logic [3:0] idx;
        case (burst[2:1])
            2'b00:   idx = 4'd0;
            2'b01:   idx = 4'd3;
            2'b10:   idx = 4'd7;
            default: idx = 4'd15;
        endcase
        return idx;
    endfunction

    // Pull the owner's bus signals out of the per-master vectors using the one-hot grant.
    always_comb begin
        own_trans = HTRANS_IDLE;
        own_burst = HBURST_SINGLE;
        own_sel   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                own_trans = htrans_m[2*i +: 2];
                own_burst = hburst_m[3*i +: 3];
                own_sel   = MSEL_W'(i);
            end
        end
    end

    assign own_req = |(hreq & grant_q);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        incr_cnt_d  = incr_cnt_q;
        in_incr_d   = in_incr_q;
        incr_next   = incr_cnt_q;
        last_fixed  = 1'b0;
        incr_limit  = 1'b0;
        release_own = 1'b0;
        do_grant    = 1'b0;
        grant_req   = '0;
        winner      = '0;
        others      = hreq & ~grant_q;

        if (hready) begin
            if (state_q == ARB_IDLE) begin
                if (|hreq) begin
                    do_grant  = 1'b1;
                    grant_req = hreq;
                end
            end else begin
                // Beat accounting for the owner's accepted transfer
                if (own_trans == HTRANS_NONSEQ) begin
                    in_incr_d  = (own_burst == HBURST_INCR);
                    beat_cnt_d = burst_last_idx(own_burst);
                    incr_next  = CNT_W'(1);
                    last_fixed = (own_burst == HBURST_SINGLE);
                end else if (own_trans == HTRANS_SEQ) begin
                    if (in_incr_q) begin
                        if (incr_cnt_q < INCR_LIMIT) begin
                            incr_next = incr_cnt_q + 1'b1;
                        end
                    end else if (beat_cnt_q != 4'd0) begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                        last_fixed = (beat_cnt_q == 4'd1);
                    end
                end
                incr_cnt_d = incr_next;

                incr_limit  = in_incr_d && (incr_next >= INCR_LIMIT) && (|others);
                release_own = !own_req || (own_trans == HTRANS_IDLE) || last_fixed || incr_limit;

                if (release_own) begin
                    if (|others) begin
                        do_grant  = 1'b1;
                        grant_req = others;
                    end else if (own_req) begin
                        // Sole remaining requester is handed the grant again.
                        do_grant  = 1'b1;
                        grant_req = grant_q;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end
            end

            if (do_grant) begin
                winner          = rr_pick(grant_req, rr_ptr_q);
                grant_d         = '0;
                grant_d[winner] = 1'b1;
                rr_ptr_d        = (winner == MSEL_W'(N - 1)) ? '0 : winner + 1'b1;
                state_d         = ARB_OWN;
                // Counts restart on the new owner's NONSEQ.
                beat_cnt_d      = '0;
                incr_cnt_d      = '0;
                in_incr_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            incr_cnt_q   <= '0;
            in_incr_q    <= 1'b0;
            data_sel_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            incr_cnt_q <= incr_cnt_d;
            in_incr_q  <= in_incr_d;
            // The address phase becomes the data phase when hready completes the current one.
            if (hready) begin
                data_sel_q   <= own_sel;
                data_valid_q <= (|grant_q) & own_trans[1];
            end
        end
    end

    assign hgrant           = grant_q;
    assign hmaster_sel      = own_sel;
    assign hmaster_data_sel = data_sel_q;
    assign hsel_data_valid  = data_valid_q;

endmodule
